// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master port between NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT wait cycles.
module apb_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ-1:0]        req_write_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [NUM_REQ-1:0]        done_o,
   output logic [DATA_W-1:0]         rdata_o,
   output logic                      err_o,
   output logic                      psel_o,
   output logic                      penable_o,
   output logic                      pwrite_o,
   output logic [ADDR_W-1:0]         paddr_o,
   output logic [DATA_W-1:0]         pwdata_o,
   input  logic                      pready_i,
   input  logic                      pslverr_i,
   input  logic [DATA_W-1:0]         prdata_i
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
      $error("apb_req_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_e;

   state_e              state_r, state_s;
   logic [IDX_W-1:0]    last_grant_r, last_grant_s;
   logic [IDX_W-1:0]    winner_s;
   logic [IDX_W:0]      cand_s;
   logic                found_s;
   logic [NUM_REQ-1:0]  gnt_r, gnt_s, done_r, done_s;
   logic [DATA_W-1:0]   rdata_r, rdata_s, pwdata_r, pwdata_s;
   logic [ADDR_W-1:0]   paddr_r, paddr_s;
   logic                err_r, err_s, psel_r, psel_s, penable_r, penable_s, pwrite_r, pwrite_s;
`ifdef APB_ARB_TIMEOUT_EN
   localparam logic [7:0] TMO_LIM_C = 8'(TIMEOUT - 1);
   logic [7:0]          tmo_cnt_r, tmo_cnt_s;
`endif

   // Round-robin pick: walk candidates from farthest to nearest after last_grant so the nearest wins.
   always_comb begin
      winner_s = last_grant_r;
      cand_s   = '0;
      found_s  = |req_i;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand_s   = {1'b0, last_grant_r} + (IDX_W+1)'(i);
         cand_s   = (cand_s >= (IDX_W+1)'(NUM_REQ)) ? cand_s - (IDX_W+1)'(NUM_REQ) : cand_s;
         winner_s = req_i[cand_s[IDX_W-1:0]] ? cand_s[IDX_W-1:0] : winner_s;
      end
   end

   // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequencer.
   always_comb begin
      state_s      = state_r;
      last_grant_s = last_grant_r;
      gnt_s        = '0;
      done_s       = '0;
      rdata_s      = rdata_r;
      err_s        = err_r;
      psel_s       = psel_r;
      penable_s    = penable_r;
      pwrite_s     = pwrite_r;
      paddr_s      = paddr_r;
      pwdata_s     = pwdata_r;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt_s    = tmo_cnt_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               state_s          = ST_SETUP;
               gnt_s[winner_s]  = 1'b1;
               last_grant_s     = winner_s;
               pwrite_s         = req_write_i[winner_s];
               paddr_s          = req_addr_i[winner_s*ADDR_W +: ADDR_W];
               pwdata_s         = req_wdata_i[winner_s*DATA_W +: DATA_W];
               psel_s           = 1'b1;
               penable_s        = 1'b0;
            end else begin
               state_s          = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_s   = ST_ACCESS;
            penable_s = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt_s = 8'd0;
`endif
         end
         ST_ACCESS: begin
            if (pready_i) begin
               state_s              = ST_IDLE;
               done_s[last_grant_r] = 1'b1;
               err_s                = pslverr_i;
               rdata_s              = pwrite_r ? {DATA_W{1'b0}} : prdata_i;
               psel_s               = 1'b0;
               penable_s            = 1'b0;
            end
`ifdef APB_ARB_TIMEOUT_EN
            // The slave has stalled TIMEOUT cycles: abort and report an error to the owner.
            else if (tmo_cnt_r == TMO_LIM_C) begin
               state_s              = ST_IDLE;
               done_s[last_grant_r] = 1'b1;
               err_s                = 1'b1;
               rdata_s              = {DATA_W{1'b0}};
               psel_s               = 1'b0;
               penable_s            = 1'b0;
            end else begin
               tmo_cnt_s            = tmo_cnt_r + 8'd1;
            end
`else
            else begin
               state_s              = ST_ACCESS;
            end
`endif
         end
         default: begin
            state_s   = ST_IDLE;
            psel_s    = 1'b0;
            penable_s = 1'b0;
         end
      endcase
   end

   // State and output registers; reset leaves requester 0 as the first winner.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         last_grant_r <= IDX_W'(NUM_REQ - 1);
         gnt_r        <= '0;
         done_r       <= '0;
         rdata_r      <= '0;
         err_r        <= 1'b0;
         psel_r       <= 1'b0;
         penable_r    <= 1'b0;
         pwrite_r     <= 1'b0;
         paddr_r      <= '0;
         pwdata_r     <= '0;
`ifdef APB_ARB_TIMEOUT_EN
         tmo_cnt_r    <= 8'd0;
`endif
      end else begin
         state_r      <= state_s;
         last_grant_r <= last_grant_s;
         gnt_r        <= gnt_s;
         done_r       <= done_s;
         rdata_r      <= rdata_s;
         err_r        <= err_s;
         psel_r       <= psel_s;
         penable_r    <= penable_s;
         pwrite_r     <= pwrite_s;
         paddr_r      <= paddr_s;
         pwdata_r     <= pwdata_s;
`ifdef APB_ARB_TIMEOUT_EN
         tmo_cnt_r    <= tmo_cnt_s;
`endif
      end
   end

   assign gnt_o     = gnt_r;
   assign done_o    = done_r;
   assign rdata_o   = rdata_r;
   assign err_o     = err_r;
   assign psel_o    = psel_r;
   assign penable_o = penable_r;
   assign pwrite_o  = pwrite_r;
   assign paddr_o   = paddr_r;
   assign pwdata_o  = pwdata_r;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin/APB model.
module tb_apb_req_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk, reset;
   logic [N-1:0]  req, req_write, gnt, done;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0] rdata, pwdata, prdata;
   logic [AW-1:0] paddr;
   logic          err, psel, penable, pwrite, pready, pslverr;

   int checks   = 0;
   int failures = 0;

   apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset), .req_i(req), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .gnt_o(gnt), .done_o(done),
      .rdata_o(rdata), .err_o(err), .psel_o(psel), .penable_o(penable),
      .pwrite_o(pwrite), .paddr_o(paddr), .pwdata_o(pwdata),
      .pready_i(pready), .pslverr_i(pslverr), .prdata_i(prdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
      req_write[k]          = w;
      req_addr[k*AW +: AW]  = a;
      req_wdata[k*DW +: DW] = d;
   endtask

   task automatic test_reset();
      reset = 1'b1; req = 4'hF; pready = 1'b1; pslverr = 1'b1; prdata = 32'hFFFF_FFFF;
      tick(); tick(); tick();
      checks++;
      if ({gnt, done, psel, penable, pwrite, paddr, pwdata, rdata, err} !== 108'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", {gnt, done, psel, penable, pwrite, paddr, pwdata, rdata, err});
      end
      reset = 1'b0; req = 4'h0; pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
      tick();
   endtask

   task automatic test_single_read();
      set_cmd(2, 1'b0, 32'hDEAD_CAFE, 32'h1111_2222);
      req = 4'b0100;
      tick();
      checks++;
      if ({gnt, psel, penable, pwrite, paddr} !== {4'b0100, 1'b1, 1'b0, 1'b0, 32'hDEAD_CAFE}) begin
         failures++;
         $display("FAIL read_setup got gnt=%b psel=%b pen=%b pw=%b addr=%h exp 0100/1/0/0/deadcafe", gnt, psel, penable, pwrite, paddr);
      end
      req = 4'b0000;
      tick();
      checks++;
      if ({gnt, psel, penable} !== {4'b0000, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL read_access got gnt=%b psel=%b pen=%b exp 0000/1/1", gnt, psel, penable);
      end
      pready = 1'b1; prdata = 32'h1234_5678; pslverr = 1'b0;
      tick();
      checks++;
      if ({done, rdata, err, psel, penable} !== {4'b0100, 32'h1234_5678, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL read_done got done=%b rdata=%h err=%b psel=%b pen=%b exp 0100/12345678/0/0/0", done, rdata, err, psel, penable);
      end
      pready = 1'b0;
      tick();
      checks++;
      if (done !== 4'b0000) begin
         failures++;
         $display("FAIL read_done_pulse got=%b exp=0000", done);
      end
   endtask

   task automatic test_all_four();
      logic [3:0] eg, ed;
      reset = 1'b1; req = 4'hF; pready = 1'b1; pslverr = 1'b0;
      for (int k = 0; k < N; k++) set_cmd(k, 1'b0, $urandom, $urandom);
      tick();
      reset = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         prdata = $urandom;
         tick();
         eg = ((c - 1) % 3 == 0) ? 4'(1 << (((c - 1) / 3) % 4)) : 4'b0000;
         ed = (c % 3 == 0) ? 4'(1 << ((c / 3 - 1) % 4)) : 4'b0000;
         checks++;
         if (gnt !== eg) begin
            failures++;
            $display("FAIL all4_gnt cycle=%0d got=%b exp=%b", c, gnt, eg);
         end
         checks++;
         if (done !== ed) begin
            failures++;
            $display("FAIL all4_done cycle=%0d got=%b exp=%b", c, done, ed);
         end
      end
      req = 4'h0; pready = 1'b0;
      tick();
   endtask

   task automatic test_wait_err();
      logic [31:0] a;
      a = $urandom;
      set_cmd(1, 1'b1, a, 32'h0000_0005);
      req = 4'b0010; pready = 1'b0; pslverr = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 1) begin
            checks++;
            if (gnt !== 4'b0010) begin
               failures++;
               $display("FAIL wait_gnt got=%b exp=0010", gnt);
            end
            req = 4'b0000;
         end
         checks++;
         if ({psel, penable, pwrite, paddr, pwdata, done} !== {1'b1, (c != 1), 1'b1, a, 32'h5, 4'b0000}) begin
            failures++;
            $display("FAIL wait_hold cycle=%0d got psel=%b pen=%b pw=%b addr=%h wd=%h done=%b exp addr=%h wd=5", c, psel, penable, pwrite, paddr, pwdata, done, a);
         end
         if (c == 5) begin
            pready = 1'b1; pslverr = 1'b1; prdata = 32'hA5A5_A5A5;
         end
      end
      tick();
      checks++;
      if ({done, err, rdata, psel} !== {4'b0010, 1'b1, 32'h0, 1'b0}) begin
         failures++;
         $display("FAIL wait_done got done=%b err=%b rdata=%h psel=%b exp 0010/1/0/0", done, err, rdata, psel);
      end
      pready = 1'b0; pslverr = 1'b0;
   endtask

   task automatic test_fairness();
      logic [3:0] eg, ed;
      set_cmd(3, 1'b0, $urandom, $urandom);
      set_cmd(1, 1'b0, $urandom, $urandom);
      req = 4'b1000; pready = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick();
         case (c)
            1: req = 4'b0000;
            3: req = 4'b1010;
            4: req = 4'b1000;
            7: req = 4'b0000;
            default: ;
         endcase
         eg = (c == 1) ? 4'b1000 : (c == 4) ? 4'b0010 : (c == 7) ? 4'b1000 : 4'b0000;
         ed = (c == 3) ? 4'b1000 : (c == 6) ? 4'b0010 : (c == 9) ? 4'b1000 : 4'b0000;
         checks++;
         if ({gnt, done} !== {eg, ed}) begin
            failures++;
            $display("FAIL fair cycle=%0d got gnt=%b done=%b exp gnt=%b done=%b", c, gnt, done, eg, ed);
         end
      end
      pready = 1'b0;
   endtask

   task automatic test_reset_mid();
      set_cmd(2, 1'b1, $urandom, $urandom);
      req = 4'b0100; pready = 1'b0;
      tick();
      req = 4'b0000;
      tick();
      tick();
      checks++;
      if ({psel, penable} !== 2'b11) begin
         failures++;
         $display("FAIL rstmid_access got psel=%b pen=%b exp 1/1", psel, penable);
      end
      reset = 1'b1; pready = 1'b1; pslverr = 1'b1;
      tick();
      checks++;
      if ({gnt, done, psel, penable, pwrite, paddr, pwdata, rdata, err} !== 108'd0) begin
         failures++;
         $display("FAIL rstmid_outputs got=%h exp=0", {gnt, done, psel, penable, pwrite, paddr, pwdata, rdata, err});
      end
      reset = 1'b0; pready = 1'b0; pslverr = 1'b0; req = 4'hF;
      tick();
      checks++;
      if ({gnt, done} !== {4'b0001, 4'b0000}) begin
         failures++;
         $display("FAIL rstmid_prio got gnt=%b done=%b exp 0001/0000", gnt, done);
      end
      req = 4'h0; pready = 1'b1;
      tick();
      tick();
      checks++;
      if (done !== 4'b0001) begin
         failures++;
         $display("FAIL rstmid_after got done=%b exp=0001", done);
      end
      pready = 1'b0;
   endtask

   task automatic test_timeout();
      set_cmd(3, 1'b0, $urandom, $urandom);
      req = 4'b1000; pready = 1'b0;
      tick();
      req = 4'b0000;
`ifdef APB_ARB_TIMEOUT_EN
      for (int c = 2; c <= 6; c++) begin
         tick();
         if (c < 6) begin
            checks++;
            if ({psel, penable, done} !== {1'b1, 1'b1, 4'b0000}) begin
               failures++;
               $display("FAIL tmo_wait cycle=%0d got psel=%b pen=%b done=%b", c, psel, penable, done);
            end
         end
      end
      checks++;
      if ({done, err, rdata, psel, penable} !== {4'b1000, 1'b1, 32'h0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL tmo_abort got done=%b err=%b rdata=%h psel=%b pen=%b", done, err, rdata, psel, penable);
      end
      pready = 1'b1; prdata = 32'h5555_AAAA;
      tick();
      tick();
      checks++;
      if ({done, psel} !== {4'b0000, 1'b0}) begin
         failures++;
         $display("FAIL tmo_late got done=%b psel=%b exp 0000/0", done, psel);
      end
`else
      begin
         int held;
         held = 0;
         for (int c = 0; c < 110; c++) begin
            tick();
            if (psel && penable && done == 4'b0000) held++;
         end
         checks++;
         if (held != 110) begin
            failures++;
            $display("FAIL notmo_hold got=%0d cycles exp=110", held);
         end
         pready = 1'b1; prdata = 32'h5555_AAAA; pslverr = 1'b0;
         tick();
         checks++;
         if ({done, err, rdata} !== {4'b1000, 1'b0, 32'h5555_AAAA}) begin
            failures++;
            $display("FAIL notmo_done got done=%b err=%b rdata=%h", done, err, rdata);
         end
      end
`endif
      pready = 1'b0;
      tick();
   endtask

   task automatic test_random();
      bit          pend[N];
      logic        pw[N];
      logic [31:0] pa[N], pd[N];
      int          last, owner, g_cyc, wcnt, cyc, k, n;
      bit          busy, cw, c_err, drained, anyp;
      logic [31:0] ca, cd, c_rdata;
      logic [3:0]  eg, ed;
      logic        ep, ee;
      reset = 1'b1; req = 4'h0;
      tick(); tick();
      reset = 1'b0;
      for (int j = 0; j < N; j++) pend[j] = 1'b0;
      last = N - 1; busy = 1'b0; cyc = 0; owner = 0; g_cyc = 0; wcnt = 0;
      cw = 1'b0; c_err = 1'b0; ca = 32'h0; cd = 32'h0; c_rdata = 32'h0;
      drained = 1'b0; n = 0;
      while (n < 700 && !drained) begin
         tick();
         cyc++;
         k = -1;
         if (!busy) begin
            for (int i = 1; i <= N; i++) begin
               if (k < 0 && pend[(last + i) % N]) k = (last + i) % N;
            end
         end
         eg = (k >= 0) ? 4'(1 << k) : 4'b0000;
         ed = (busy && cyc == g_cyc + 2 + wcnt) ? 4'(1 << owner) : 4'b0000;
         ep = (k >= 0) || (busy && cyc <= g_cyc + 1 + wcnt);
         ee = busy && cyc >= g_cyc + 1 && cyc <= g_cyc + 1 + wcnt;
         checks++;
         if ({gnt, done, psel, penable} !== {eg, ed, ep, ee}) begin
            failures++;
            $display("FAIL rnd_ctrl cyc=%0d got gnt=%b done=%b psel=%b pen=%b exp gnt=%b done=%b psel=%b pen=%b", cyc, gnt, done, psel, penable, eg, ed, ep, ee);
         end
         if (ed != 4'b0000) begin
            checks++;
            if ({err, rdata} !== {c_err, (cw ? 32'h0 : c_rdata)}) begin
               failures++;
               $display("FAIL rnd_resp cyc=%0d got err=%b rdata=%h exp err=%b rdata=%h", cyc, err, rdata, c_err, (cw ? 32'h0 : c_rdata));
            end
         end
         if (k >= 0) begin
            checks++;
            if ({pwrite, paddr, pwdata} !== {pw[k], pa[k], pd[k]}) begin
               failures++;
               $display("FAIL rnd_cmd_latch cyc=%0d got w=%b a=%h d=%h exp w=%b a=%h d=%h", cyc, pwrite, paddr, pwdata, pw[k], pa[k], pd[k]);
            end
         end else if (ep) begin
            checks++;
            if ({pwrite, paddr, pwdata} !== {cw, ca, cd}) begin
               failures++;
               $display("FAIL rnd_cmd_hold cyc=%0d got w=%b a=%h d=%h exp w=%b a=%h d=%h", cyc, pwrite, paddr, pwdata, cw, ca, cd);
            end
         end
         if (ed != 4'b0000) busy = 1'b0;
         if (k >= 0) begin
            busy = 1'b1; owner = k; g_cyc = cyc; wcnt = $urandom_range(0, 3); last = k;
            cw = pw[k]; ca = pa[k]; cd = pd[k];
            c_err = 1'($urandom_range(0, 1)); c_rdata = $urandom;
            if ($urandom_range(0, 1) == 1) begin
               pw[k] = 1'($urandom_range(0, 1)); pa[k] = $urandom; pd[k] = $urandom;
            end else begin
               pend[k] = 1'b0;
            end
         end
         for (int j = 0; j < N; j++) begin
            if (n < 500 && !pend[j] && $urandom_range(0, 2) == 0) begin
               pend[j] = 1'b1; pw[j] = 1'($urandom_range(0, 1)); pa[j] = $urandom; pd[j] = $urandom;
            end
            req[j] = pend[j];
            set_cmd(j, pw[j], pa[j], pd[j]);
         end
         if (busy && cyc >= g_cyc + 1 && cyc <= g_cyc + 1 + wcnt) begin
            if (cyc == g_cyc + 1 + wcnt) begin
               pready = 1'b1; pslverr = c_err; prdata = c_rdata;
            end else begin
               pready = 1'b0; pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
            end
         end else begin
            pready = 1'($urandom_range(0, 1)); pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
         end
         anyp = 1'b0;
         for (int j = 0; j < N; j++) anyp = anyp | pend[j];
         if (n >= 500 && !busy && !anyp) drained = 1'b1;
         n++;
      end
      checks++;
      if (!drained) begin
         failures++;
         $display("FAIL rnd_drain got busy=%b after %0d cycles exp idle", busy, n);
      end
      req = 4'h0; pready = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req = 4'h0; req_write = 4'h0; req_addr = '0; req_wdata = '0;
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
      test_reset();
      test_single_read();
      test_all_four();
      test_wait_err();
      test_fairness();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
